// File: rtl/clkdiv_mc_if.sv
// Config request port for clkdiv_mc: one valid/ready slot carrying target channel, divisor and phase.
// Latency: none (bundle of wires).
// Backpressure: master holds cfg_valid and payload stable until cfg_ready is high on a clkin edge.
interface clkdiv_mc_if #(
    parameter int CH_W  = 1,
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clkdiv_mc.sv
// Multi-channel programmable clock divider: per-channel divided level + one-cycle enable after lock settle.
// Latency: outputs registered one cycle after the counter; config applied at the channel's next period end.
// Backpressure: one pending slot, cfg_ready low while it is full or before lock; CLKDIV_PHASE_EN adds phase delay.
module clkdiv_mc #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 64,
    parameter int DEFAULT_DIV = 10,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clkin,
    input  logic              i_reset,
    clkdiv_mc_if.slave        cfg,
    output logic [NUM_CH-1:0] o_clkoutd,
    output logic [NUM_CH-1:0] o_clk_en,
    output logic              o_lock
);
    localparam int               LCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    typedef enum logic {G_LOCKING, G_LOCKED} g_state_e;
    typedef enum logic [1:0] {CH_HOLD, CH_RUN, CH_SHIFT} ch_state_e;

    g_state_e          r_gstate;
    logic [LCK_W-1:0]  r_lock_cnt;
    logic              r_lock;
    logic              r_pend_vld;
    logic [CH_W-1:0]   r_pend_ch;
    logic [DIV_W-1:0]  r_pend_div;

    ch_state_e         r_state [NUM_CH];
    logic [DIV_W-1:0]  r_cnt   [NUM_CH];
    logic [DIV_W-1:0]  r_div   [NUM_CH];
    logic [NUM_CH-1:0] r_clkoutd;
    logic [NUM_CH-1:0] r_clk_en;

    logic              w_lock_go;
    logic              w_cfg_ready;
    logic              w_xfer;
    logic              w_ch_ok;
    logic [DIV_W-1:0]  w_new_div;
    logic [NUM_CH-1:0] w_last;
    logic [NUM_CH-1:0] w_apply;

`ifdef CLKDIV_PHASE_EN
    logic [DIV_W-1:0]  r_pend_ph;
    logic [DIV_W-1:0]  r_ph_cnt [NUM_CH];
    logic [DIV_W-1:0]  w_new_ph;
    // a phase at or beyond the new period would swallow a whole period, so cap it at N-1
    assign w_new_ph = (cfg.cfg_phase >= w_new_div) ? (w_new_div - 1'b1) : cfg.cfg_phase;
`else
    logic              w_unused_phase;
    assign w_unused_phase = ^cfg.cfg_phase;
`endif

    // lock fires on the edge that completes the settle count; channels leave HOLD on that same edge
    assign w_lock_go   = (r_gstate == G_LOCKING) && (r_lock_cnt == LCK_W'(LOCK_CYCLES - 1));
    assign w_cfg_ready = r_lock && !r_pend_vld;
    assign w_xfer      = cfg.cfg_valid && w_cfg_ready;
    assign w_ch_ok     = {1'b0, cfg.cfg_ch} < CH_LIMIT;
    assign w_new_div   = (cfg.cfg_div < MIN_DIV) ? MIN_DIV : cfg.cfg_div;

    assign cfg.cfg_ready = w_cfg_ready;
    assign o_clkoutd     = r_clkoutd;
    assign o_clk_en      = r_clk_en;
    assign o_lock        = r_lock;

    // per channel: last cycle of the running period, and whether the pending update lands there
    always_comb begin
        w_last  = '0;
        w_apply = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_last[c]  = (r_state[c] == CH_RUN) && (r_cnt[c] == r_div[c] - 1'b1);
            w_apply[c] = w_last[c] && r_pend_vld && (r_pend_ch == CH_W'(c));
        end
    end

    // global lock FSM plus the single pending config slot
    always_ff @(posedge i_clkin) begin
        if (i_reset) begin
            r_gstate   <= G_LOCKING;
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_div <= '0;
`ifdef CLKDIV_PHASE_EN
            r_pend_ph  <= '0;
`endif
        end else begin
            case (r_gstate)
                G_LOCKING: begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                    if (w_lock_go) begin
                        r_gstate <= G_LOCKED;
                        r_lock   <= 1'b1;
                    end
                end
                G_LOCKED: begin
                    // apply and transfer never coincide: ready is low while the slot is full
                    if (|w_apply) begin
                        r_pend_vld <= 1'b0;
                    end
                    // out-of-range channels are taken off the port and dropped
                    if (w_xfer && w_ch_ok) begin
                        r_pend_vld <= 1'b1;
                        r_pend_ch  <= cfg.cfg_ch;
                        r_pend_div <= w_new_div;
`ifdef CLKDIV_PHASE_EN
                        r_pend_ph  <= w_new_ph;
`endif
                    end
                end
                default: r_gstate <= G_LOCKING;
            endcase
        end
    end

    // channel FSMs: counters, registered outputs, and glitch-free divisor/phase switch at period end
    always_ff @(posedge i_clkin) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]  <= CH_HOLD;
                r_cnt[c]    <= '0;
                r_div[c]    <= DEF_DIV;
`ifdef CLKDIV_PHASE_EN
                r_ph_cnt[c] <= '0;
`endif
            end
            r_clkoutd <= '0;
            r_clk_en  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (r_state[c])
                    CH_HOLD: begin
                        r_clkoutd[c] <= 1'b0;
                        r_clk_en[c]  <= 1'b0;
                        if (w_lock_go) begin
                            r_state[c] <= CH_RUN;
                            r_cnt[c]   <= '0;
                        end
                    end
                    CH_RUN: begin
                        r_clkoutd[c] <= (r_cnt[c] < (r_div[c] >> 1));
                        r_clk_en[c]  <= (r_cnt[c] == '0);
                        if (w_last[c]) begin
                            r_cnt[c] <= '0;
                            if (w_apply[c]) begin
                                r_div[c] <= r_pend_div;
`ifdef CLKDIV_PHASE_EN
                                if (r_pend_ph != '0) begin
                                    r_state[c]  <= CH_SHIFT;
                                    r_ph_cnt[c] <= r_pend_ph;
                                end
`endif
                            end
                        end else begin
                            r_cnt[c] <= r_cnt[c] + 1'b1;
                        end
                    end
`ifdef CLKDIV_PHASE_EN
                    CH_SHIFT: begin
                        // outputs parked low for the phase delay, then a fresh period from cnt 0
                        r_clkoutd[c] <= 1'b0;
                        r_clk_en[c]  <= 1'b0;
                        r_ph_cnt[c]  <= r_ph_cnt[c] - 1'b1;
                        if (r_ph_cnt[c] == DIV_W'(1)) begin
                            r_state[c] <= CH_RUN;
                            r_cnt[c]   <= '0;
                        end
                    end
`endif
                    default: begin
                        r_state[c]   <= CH_HOLD;
                        r_clkoutd[c] <= 1'b0;
                        r_clk_en[c]  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clkdiv_mc.sv
// Bench for clkdiv_mc: expected clk_en periods are queued per channel when stimulus is driven,
// and a negedge monitor pops them and compares clk_en/clkoutd every cycle.
// A second small instance (3 channels) covers the out-of-range channel case.
module tb_clkdiv_mc;
    localparam int NCH  = 2;
    localparam int DW   = 8;
    localparam int LOCK = 64;
    localparam int DEFN = 10;

    typedef struct {
        int at;
        int n;
    } per_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    clkdiv_mc_if #(.CH_W(1), .DIV_W(DW)) cif ();
    clkdiv_mc_if #(.CH_W(2), .DIV_W(DW)) cif2 ();

    logic [NCH-1:0] clkoutd, clk_en;
    logic           lock;
    logic [2:0]     clkoutd2, clk_en2;
    logic           lock2;

    clkdiv_mc #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LOCK), .DEFAULT_DIV(DEFN)) u_dut (
        .i_clkin(clk), .i_reset(rst), .cfg(cif),
        .o_clkoutd(clkoutd), .o_clk_en(clk_en), .o_lock(lock)
    );

    clkdiv_mc #(.NUM_CH(3), .DIV_W(DW), .LOCK_CYCLES(4), .DEFAULT_DIV(4)) u_dut2 (
        .i_clkin(clk), .i_reset(rst), .cfg(cif2),
        .o_clkoutd(clkoutd2), .o_clk_en(clk_en2), .o_lock(lock2)
    );

    // scoreboard state
    per_t sq [NCH][$];
    int   act_start [NCH];
    int   act_n     [NCH];
    int   gen_next  [NCH];
    int   gen_n     [NCH];
    bit   gen_on = 0;
    bit   mon_en = 0;
    int   rel_edge = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor: pop scheduled periods and compare both outputs of every channel each cycle
    always @(negedge clk) begin
        per_t e;
        bit   exp_en;
        bit   exp_hi;
        int   off;
        if (mon_en) begin
            for (int c = 0; c < NCH; c++) begin
                while (sq[c].size() > 0 && sq[c][0].at < cyc) void'(sq[c].pop_front());
                exp_en = 1'b0;
                if (sq[c].size() > 0 && sq[c][0].at == cyc) begin
                    exp_en       = 1'b1;
                    act_start[c] = cyc;
                    act_n[c]     = sq[c][0].n;
                    void'(sq[c].pop_front());
                end
                off    = cyc - act_start[c];
                exp_hi = (act_start[c] >= 0) && (off < act_n[c] / 2);
                n_checks++;
                if (clk_en[c] !== exp_en) begin
                    n_fail++;
                    $display("FAIL clk_en ch%0d edge %0d: got %b expected %b", c, cyc, clk_en[c], exp_en);
                end
                n_checks++;
                if (clkoutd[c] !== exp_hi) begin
                    n_fail++;
                    $display("FAIL clkoutd ch%0d edge %0d: got %b expected %b", c, cyc, clkoutd[c], exp_hi);
                end
                if (gen_on) begin
                    while (gen_next[c] <= cyc + 40) begin
                        e.at = gen_next[c];
                        e.n  = gen_n[c];
                        sq[c].push_back(e);
                        gen_next[c] += gen_n[c];
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            sq[c].delete();
            act_start[c] = -1;
            act_n[c]     = 0;
        end
        gen_on = 0;
    endtask

    task automatic model_lock(input int r);
        for (int c = 0; c < NCH; c++) begin
            gen_next[c] = r + LOCK + 1;
            gen_n[c]    = DEFN;
        end
        gen_on = 1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // drive one config transfer on the main DUT and reschedule the target channel's periods
    task automatic cfg_write(input int ch, input int div, input int ph,
                             output bit ok, output int acc_e, output int apply_e);
        int n_new, p_new, ce, cn, tries;
        bit found;
        cif.cfg_ch    = 1'(ch);
        cif.cfg_div   = 8'(div);
        cif.cfg_phase = 8'(ph);
        cif.cfg_valid = 1'b1;
        tries = 0;
        while (cif.cfg_ready !== 1'b1 && tries < 50) begin
            @(posedge clk); #1;
            tries++;
        end
        ok = (cif.cfg_ready === 1'b1);
        @(posedge clk); #1;
        acc_e = cyc;
        cif.cfg_valid = 1'b0;
        n_new = (div < 2) ? 2 : div;
`ifdef CLKDIV_PHASE_EN
        p_new = (ph >= n_new) ? n_new - 1 : ph;
`else
        p_new = 0;
`endif
        found = 0;
        ce = 0;
        cn = 0;
        if (act_start[ch] >= 0 && act_start[ch] + act_n[ch] - 1 >= acc_e + 1) begin
            ce = act_start[ch];
            cn = act_n[ch];
            found = 1;
        end
        for (int i = 0; i < sq[ch].size() && !found; i++) begin
            if (sq[ch][i].at + sq[ch][i].n - 1 >= acc_e + 1) begin
                ce = sq[ch][i].at;
                cn = sq[ch][i].n;
                found = 1;
            end
        end
        while (sq[ch].size() > 0 && sq[ch][sq[ch].size() - 1].at > ce) void'(sq[ch].pop_back());
        gen_next[ch] = ce + cn + p_new;
        gen_n[ch]    = n_new;
        apply_e      = ce + cn - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        mon_en = 1;
        n_checks++;
        if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b expected 0", lock); end
        n_checks++;
        if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cif.cfg_ready); end
        n_checks++;
        if (clkoutd !== '0 || clk_en !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: clkoutd %b clk_en %b expected 00 00", clkoutd, clk_en);
        end
        rst = 1'b0;
        rel_edge = cyc;
        model_lock(rel_edge);
        wait_until(rel_edge + LOCK - 1);
        n_checks++;
        if (lock !== 1'b0) begin n_fail++; $display("FAIL lock_early edge %0d: got %b expected 0", cyc, lock); end
        n_checks++;
        if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ready_prelock: got %b expected 0", cif.cfg_ready); end
        wait_until(rel_edge + LOCK);
        n_checks++;
        if (lock !== 1'b1) begin n_fail++; $display("FAIL lock_rise edge %0d: got %b expected 1", cyc, lock); end
        n_checks++;
        if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_locked: got %b expected 1", cif.cfg_ready); end
    endtask

    task automatic test_divisor_update();
        bit ok;
        int acc_e, apply_e;
        wait_until(rel_edge + LOCK + 4);
        cfg_write(1, 3, 0, ok, acc_e, apply_e);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL div_accept: cfg_ready %b expected 1", cif.cfg_ready); end
        n_checks++;
        if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL div_ready_drop: got %b expected 0", cif.cfg_ready); end
        wait_until(apply_e - 1);
        n_checks++;
        if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL div_ready_held edge %0d: got %b expected 0", cyc, cif.cfg_ready); end
        wait_until(apply_e);
        n_checks++;
        if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL div_ready_return edge %0d: got %b expected 1", cyc, cif.cfg_ready); end
        wait_until(cyc + 30);
    endtask

    task automatic test_phase();
        bit ok;
        int acc_e, apply_e;
        cfg_write(0, 4, 2, ok, acc_e, apply_e);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL phase_accept: cfg_ready %b expected 1", cif.cfg_ready); end
        wait_until(apply_e);
        n_checks++;
        if (cif.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL phase_ready_return edge %0d: got %b expected 1", cyc, cif.cfg_ready); end
        wait_until(cyc + 25);
    endtask

    task automatic test_clamp();
        bit ok;
        int acc_e, apply_e;
        cfg_write(1, 0, 0, ok, acc_e, apply_e);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL clamp_div_accept: cfg_ready %b expected 1", cif.cfg_ready); end
        wait_until(apply_e + 12);
        cfg_write(0, 4, 9, ok, acc_e, apply_e);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL clamp_ph_accept: cfg_ready %b expected 1", cif.cfg_ready); end
        wait_until(apply_e + 25);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int acc_e, apply_e;
        cfg_write(1, 20, 0, ok, acc_e, apply_e);
        wait_until(apply_e + 25);
        cfg_write(1, 5, 0, ok, acc_e, apply_e);
        n_checks++;
        if (!ok || cif.cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pending: accepted %b ready %b expected 1 0", ok, cif.cfg_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        n_checks++;
        if (clkoutd !== '0 || clk_en !== '0 || lock !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: clkoutd %b clk_en %b lock %b expected all 0", clkoutd, clk_en, lock);
        end
        n_checks++;
        if (cif.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", cif.cfg_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rel_edge = cyc;
        model_lock(rel_edge);
        wait_until(rel_edge + LOCK);
        n_checks++;
        if (lock !== 1'b1) begin n_fail++; $display("FAIL relock edge %0d: got %b expected 1", cyc, lock); end
        wait_until(rel_edge + LOCK + 45);
    endtask

    task automatic test_invalid_channel();
        int tries, en_cnt[3], hi_cnt[3];
        tries = 0;
        while (cif2.cfg_ready !== 1'b1 && tries < 50) begin
            @(posedge clk); #1;
            tries++;
        end
        cif2.cfg_ch    = 2'd3;
        cif2.cfg_div   = 8'd2;
        cif2.cfg_phase = 8'd0;
        cif2.cfg_valid = 1'b1;
        @(posedge clk); #1;
        cif2.cfg_valid = 1'b0;
        n_checks++;
        if (cif2.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready_stays: got %b expected 1", cif2.cfg_ready); end
        @(posedge clk); #1;
        n_checks++;
        if (cif2.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready_next: got %b expected 1", cif2.cfg_ready); end
        for (int c = 0; c < 3; c++) begin en_cnt[c] = 0; hi_cnt[c] = 0; end
        repeat (12) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                en_cnt[c] += int'(clk_en2[c]);
                hi_cnt[c] += int'(clkoutd2[c]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (en_cnt[c] != 3) begin n_fail++; $display("FAIL inv_en_count ch%0d: got %0d expected 3", c, en_cnt[c]); end
            n_checks++;
            if (hi_cnt[c] != 6) begin n_fail++; $display("FAIL inv_high_count ch%0d: got %0d expected 6", c, hi_cnt[c]); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        cif.cfg_valid  = 1'b0;
        cif.cfg_ch     = '0;
        cif.cfg_div    = '0;
        cif.cfg_phase  = '0;
        cif2.cfg_valid = 1'b0;
        cif2.cfg_ch    = '0;
        cif2.cfg_div   = '0;
        cif2.cfg_phase = '0;
        for (int c = 0; c < NCH; c++) begin
            act_start[c] = -1;
            act_n[c]     = 0;
            gen_next[c]  = 0;
            gen_n[c]     = DEFN;
        end
        test_reset();
        test_divisor_update();
        test_phase();
        test_clamp();
        test_reset_mid();
        test_invalid_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
